// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - RV32I opcode constants, ALU/format enums and the decoded-bundle type
package decode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_e;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rd;
        alu_op_e     alu_op;
        fmt_e        fmt;
        logic        reg_write;
        logic        illegal;
    } decoded_t;

    // alt selects SUB/SRA on the two funct3 codes that have an alternate form
    function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - combinational RV32I format classification and sign-extended immediate
module imm_gen
    import decode_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [31:0] imm_o,
    output fmt_e        fmt_o
);

    always_comb begin
        fmt_o = FMT_R;
        imm_o = '0;
        case (instr_i[6:0])
            OPC_LUI, OPC_AUIPC: begin
                fmt_o = FMT_U;
                imm_o = {instr_i[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt_o = FMT_J;
                imm_o = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
            end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
                fmt_o = FMT_I;
                imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OPC_STORE: begin
                fmt_o = FMT_S;
                imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OPC_BRANCH: begin
                fmt_o = FMT_B;
                imm_o = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - RV32I decode stage with one-entry output register
// Optional writeback bypass into captured/held operands: DECODE_WB_BYPASS_EN
module instr_decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rf_rd_address_a,
    output logic [4:0]      rf_rd_address_b,
    input  logic [XLEN-1:0] rf_data_a,
    input  logic [XLEN-1:0] rf_data_b,
    input  logic            wb_enable,
    input  logic [4:0]      wb_address,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic [3:0]      out_alu_op,
    output logic [2:0]      out_fmt,
    output logic            out_reg_write,
    output logic            out_illegal
);

    localparam decoded_t RESET_BUNDLE = '{
        pc: RESET_PC, rs1_data: '0, rs2_data: '0, imm: '0, rd: '0,
        alu_op: ALU_ADD, fmt: FMT_R, reg_write: 1'b0, illegal: 1'b0
    };

    logic        valid_q, valid_d;
    decoded_t    bundle_q, bundle_d;
    decoded_t    dec;
    logic        accept;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1, rs2;
    logic [31:0] imm;
    fmt_e        fmt;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];

    assign rf_rd_address_a = rs1;
    assign rf_rd_address_b = rs2;
    assign in_ready        = !valid_q || out_ready;
    assign accept          = in_valid && in_ready;

    imm_gen u_imm_gen (
        .instr_i (in_instr),
        .imm_o   (imm),
        .fmt_o   (fmt)
    );

    always_comb begin : decode
        dec          = RESET_BUNDLE;
        dec.pc       = in_pc;
        dec.imm      = imm;
        dec.fmt      = fmt;
        dec.rs1_data = rf_data_a;
        dec.rs2_data = rf_data_b;
        case (opcode)
            OPC_LUI:                                dec.alu_op = ALU_PASSB;
            OPC_AUIPC, OPC_JAL, OPC_JALR:           dec.alu_op = ALU_ADD;
            OPC_LOAD:   dec.illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
            OPC_STORE:  dec.illegal = (funct3 > 3'b010);
            OPC_BRANCH: begin
                dec.alu_op  = ALU_SUB;
                dec.illegal = (funct3[2:1] == 2'b01);
            end
            OPC_OP_IMM: begin
                dec.alu_op  = alu_from_funct3(funct3, (funct3 == 3'b101) && funct7[5]);
                dec.illegal = ((funct3 == 3'b001) && (funct7 != 7'b0000000)) ||
                              ((funct3 == 3'b101) && (funct7 != 7'b0000000) && (funct7 != 7'b0100000));
            end
            OPC_OP: begin
                dec.alu_op  = alu_from_funct3(funct3, funct7[5] && ((funct3 == 3'b000) || (funct3 == 3'b101)));
                dec.illegal = !((funct7 == 7'b0000000) ||
                                ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            default:    dec.illegal = 1'b1;
        endcase
        dec.rd        = ((fmt == FMT_S) || (fmt == FMT_B)) ? 5'd0 : in_instr[11:7];
        dec.reg_write = (fmt != FMT_S) && (fmt != FMT_B) && (dec.rd != 5'd0) && !dec.illegal;
`ifdef DECODE_WB_BYPASS_EN
        if (wb_enable && (wb_address != 5'd0) && (wb_address == rs1)) dec.rs1_data = wb_data;
        if (wb_enable && (wb_address != 5'd0) && (wb_address == rs2)) dec.rs2_data = wb_data;
`endif
    end

`ifdef DECODE_WB_BYPASS_EN
    // Source indices of the held instruction, needed to match later writebacks
    logic [4:0] rs1_q, rs2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_q <= '0;
            rs2_q <= '0;
        end else if (accept && !flush) begin
            rs1_q <= rs1;
            rs2_q <= rs2;
        end
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wb_enable, wb_address, wb_data};
`endif

    always_comb begin : next_state
        valid_d  = valid_q;
        bundle_d = bundle_q;
        if (flush)          valid_d = 1'b0;
        else if (accept)    valid_d = 1'b1;
        else if (out_ready) valid_d = 1'b0;

        if (accept && !flush) begin
            bundle_d = dec;
        end
`ifdef DECODE_WB_BYPASS_EN
        else if (valid_q && !out_ready) begin
            if (wb_enable && (wb_address != 5'd0) && (wb_address == rs1_q)) bundle_d.rs1_data = wb_data;
            if (wb_enable && (wb_address != 5'd0) && (wb_address == rs2_q)) bundle_d.rs2_data = wb_data;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            bundle_q <= RESET_BUNDLE;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_pc        = bundle_q.pc;
    assign out_rs1_data  = bundle_q.rs1_data;
    assign out_rs2_data  = bundle_q.rs2_data;
    assign out_imm       = bundle_q.imm;
    assign out_rd        = bundle_q.rd;
    assign out_alu_op    = bundle_q.alu_op;
    assign out_fmt       = bundle_q.fmt;
    assign out_reg_write = bundle_q.reg_write;
    assign out_illegal   = bundle_q.illegal;

endmodule
